finv_pipe: RTL and testbench

- Parametrised, handshaked successor to the two-stage mantissa-reciprocal unit: table lookup plus linear interpolation of 1/mantissa.
- Adds a true IEEE-754 single reciprocal mode: exponent negation, special-value handling and flush-to-zero.
- Adds valid/ready flow control with a pass-through tag.
- Sits between the FPU issue logic and the fdiv multiplier path; also serves standalone 1/x requests.

---
 rtl/finv_pipe.sv | 133 +++++++++++++
 tb/tb_finv_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/finv_pipe.sv
// finv_pipe: three-stage handshaked reciprocal (table lookup + linear interpolation) with IEEE-754 special handling
module finv_pipe #(
    parameter int ADDR_W = 10,
    parameter int GRAD_W = 13,
    parameter int GS     = 12,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_b,
    output logic [TAG_W-1:0] out_tag
);
    localparam int L = 23 - ADDR_W;
    localparam int N = 1 << ADDR_W;

    function automatic real ideal(input int i);
        return 8388608.0 * (2.0 / (1.0 + real'(i) / real'(N)) - 1.0);
    endfunction

    function automatic longint c_val(input int i);
        longint r;
        r = longint'(ideal(i));
        return (r > 64'sh7FFFFF) ? 64'sh7FFFFF : r;
    endfunction

    function automatic longint g_val(input int i);
        real cn;
        cn = (i + 1 < N) ? real'(c_val(i + 1)) : 0.0;
        return longint'((ideal(i) - cn) * (2.0 ** GS) / (2.0 ** L));
    endfunction

    logic [22:0]       c_rom [N];
    logic [GRAD_W-1:0] g_rom [N];

    for (genvar i = 0; i < N; i++) begin : g_tab
        localparam longint CV = c_val(i);
        localparam longint GV = g_val(i);
        assign c_rom[i] = CV[22:0];
        assign g_rom[i] = GV[GRAD_W-1:0];
    end

    logic              en;
    logic              v1_q, s1_q, z1_q, md1_q;
    logic [22:0]       c1_q;
    logic [GRAD_W-1:0] g1_q;
    logic [L-1:0]      lo1_q;
    logic [7:0]        e1_q;
    logic [TAG_W-1:0]  tag1_q;
    logic              v2_q, s2_q, z2_q, md2_q;
    logic [22:0]       c2_q, p2_q, p2_d;
    logic [7:0]        e2_q;
    logic [TAG_W-1:0]  tag2_q;
    logic [L+GRAD_W-1:0] full;
    logic [22:0]       m;
    logic [31:0]       out_b_d;
    logic              out_valid_q;
    logic [31:0]       out_b_q;
    logic [TAG_W-1:0]  out_tag_q;

    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_b     = out_b_q;
    assign out_tag   = out_tag_q;

    // Stage 1: table lookup and operand field capture
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
        end else if (en) begin
            v1_q   <= in_valid;
            c1_q   <= c_rom[in_a[22:L]];
            g1_q   <= g_rom[in_a[22:L]];
            lo1_q  <= in_a[L-1:0];
            s1_q   <= in_a[31];
            e1_q   <= in_a[30:23];
            z1_q   <= in_a[22:0] == 23'h0;
            md1_q  <= in_mode;
            tag1_q <= in_tag;
        end
    end

    assign full = {{GRAD_W{1'b0}}, lo1_q} * {{L{1'b0}}, g1_q};
    assign p2_d = 23'(full >> GS);

    // Stage 2: interpolation product, remaining fields forwarded
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q <= 1'b0;
        end else if (en) begin
            v2_q   <= v1_q;
            c2_q   <= c1_q;
            p2_q   <= p2_d;
            s2_q   <= s1_q;
            e2_q   <= e1_q;
            z2_q   <= z1_q;
            md2_q  <= md1_q;
            tag2_q <= tag1_q;
        end
    end

    // Result assembly: legacy mantissa-only or full reciprocal with specials and flush-to-zero
    always_comb begin
        m = c2_q - p2_q;
        out_b_d = md2_q ? {s2_q, e2_q, m}
            : (e2_q == 8'hFF) ? (z2_q ? {s2_q, 31'h0} : 32'h7FC00000)
            : (e2_q == 8'h00) ? {s2_q, 8'hFF, 23'h0}
            : z2_q ? ((e2_q >= 8'd254) ? {s2_q, 31'h0} : {s2_q, 8'd254 - e2_q, 23'h0})
            : (e2_q >= 8'd253) ? {s2_q, 31'h0} : {s2_q, 8'd253 - e2_q, m};
    end

    // Stage 3: output register, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_b_q     <= 32'h0;
            out_tag_q   <= '0;
        end else if (en) begin
            out_valid_q <= v2_q;
            if (v2_q) begin
                out_b_q   <= out_b_d;
                out_tag_q <= tag2_q;
            end
        end
    end
endmodule

// File: tb/tb_finv_pipe.sv
// tb_finv_pipe: randomized and directed checks of finv_pipe against a real-arithmetic reciprocal model
module tb_finv_pipe;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [31:0] in_a = 32'h0, out_b;
    logic [3:0]  in_tag = 4'h0, out_tag;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    finv_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_b(out_b), .out_tag(out_tag)
    );

    // Nominal result with the allowed ulp tolerance; 2/x on [1,2) gives the result mantissa.
    function automatic logic [31:0] model_exp(input logic [31:0] a, input logic md, output int tol);
        logic        s;
        logic [7:0]  eb;
        logic [22:0] f, m;
        int          e, mr;
        real         x;
        s  = a[31];
        eb = a[30:23];
        e  = int'(eb);
        f  = a[22:0];
        x  = 1.0 + real'(f) / 8388608.0;
        mr = int'((2.0 / x - 1.0) * 8388608.0);
        m  = mr[22:0];
        tol = (f == 23'h0) ? 0 : (f[22] ? 4 : 8);
        if (md) return (f == 23'h0) ? {s, eb, 23'h7FFFFF} : {s, eb, m};
        if (e == 255) begin
            tol = 0;
            return (f != 23'h0) ? 32'h7FC00000 : {s, 31'h0};
        end
        if (e == 0) begin
            tol = 0;
            return {s, 8'hFF, 23'h0};
        end
        if (f == 23'h0) return (e >= 254) ? {s, 31'h0} : {s, 8'(254 - e), 23'h0};
        if (e >= 253) begin
            tol = 0;
            return {s, 31'h0};
        end
        return {s, 8'(253 - e), m};
    endfunction

    function automatic bit near(input logic [31:0] b, input logic [31:0] e, input int tol);
        int d;
        if ($isunknown(b) || b[31:23] !== e[31:23]) return 1'b0;
        d = int'(b[22:0]) - int'(e[22:0]);
        return d <= tol && d >= -tol;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [22:0] f;
        f = ($urandom_range(0, 7) == 0) ? 23'h0 : {10'($urandom_range(1, 1023)), 13'($urandom)};
        return {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), f};
    endfunction

    task automatic xfer(input logic [31:0] a, input logic md, input logic [3:0] t,
                        output logic [31:0] b, output logic [3:0] bt, output int lat);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = a;
        in_mode   = md;
        in_tag    = t;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        b  = out_b;
        bt = out_tag;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bit seen;
        rst = 1'b1; in_valid = 1'b1; in_a = 32'h3F800000; in_tag = 4'h5;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0; in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else n_pass++;
        n_chk++; if (out_b !== 32'h0) $display("FAIL reset_out_b got=%h want=00000000", out_b); else n_pass++;
        n_chk++; if (out_tag !== 4'h0) $display("FAIL reset_out_tag got=%h want=0", out_tag); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else n_pass++;
        seen = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (out_valid !== 1'b0) seen = 1'b1; end
        n_chk++; if (seen) $display("FAIL reset_ignored_xfer got=output want=none"); else n_pass++;
    endtask

    task automatic test_directed();
        logic [31:0] va [15] = '{32'h3F800000, 32'h40000000, 32'hC0800000, 32'h40400000, 32'h00000000,
                                 32'h80000001, 32'h7F800000, 32'h7FC00001, 32'h7F400000, 32'h7F000000,
                                 32'h00800000, 32'h40000000, 32'h7F800000, 32'hFF800000, 32'h7EC00000};
        logic [31:0] vx [15] = '{32'h3F800000, 32'h3F000000, 32'hBE800000, 32'h3EAAAAAB, 32'h7F800000,
                                 32'hFF800000, 32'h00000000, 32'h7FC00000, 32'h00000000, 32'h00000000,
                                 32'h7E800000, 32'h407FFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h00000000};
        logic        vm [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        logic [31:0] b;
        logic [3:0]  bt;
        int          lat, tol;
        for (int i = 0; i < 15; i++) begin
            tol = (i == 3) ? 4 : 0;
            xfer(va[i], vm[i], 4'(i), b, bt, lat);
            n_chk++; if (lat !== 3) $display("FAIL latency[%0d] got=%0d want=3", i, lat); else n_pass++;
            n_chk++;
            if (!near(b, vx[i], tol)) $display("FAIL directed[%0d] a=%h mode=%b got=%h want=%h tol=%0d", i, va[i], vm[i], b, vx[i], tol);
            else n_pass++;
            n_chk++; if (bt !== 4'(i)) $display("FAIL directed_tag[%0d] got=%h want=%h", i, bt, 4'(i)); else n_pass++;
        end
    endtask

    task automatic stream(input int n, input bit bp);
        logic [31:0] oa [$];
        logic        om [$];
        logic [31:0] qa [$];
        logic        qm [$];
        logic [3:0]  qt [$];
        logic [31:0] hb, eb, ea;
        logic [3:0]  ht, et;
        logic        emd;
        int          sent, recv, cyc, tol;
        bit          stalled, acc;
        sent = 0; recv = 0; cyc = 0; stalled = 1'b0; hb = 32'h0; ht = 4'h0;
        for (int i = 0; i < n; i++) begin
            oa.push_back(rand_op());
            om.push_back(1'($urandom_range(0, 1)));
        end
        while (recv < n && cyc < 4 * n + 50) begin
            out_ready = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            in_valid  = sent < n;
            if (sent < n) begin
                in_a = oa[sent]; in_mode = om[sent]; in_tag = 4'(sent);
            end
            #1;
            if (stalled) begin
                n_chk++;
                if (out_valid !== 1'b1 || out_b !== hb || out_tag !== ht)
                    $display("FAIL stall_hold got=%b/%h/%h want=1/%h/%h", out_valid, out_b, out_tag, hb, ht);
                else n_pass++;
            end
            if (out_valid === 1'b1 && out_ready === 1'b0) begin
                n_chk++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got=%b want=0", in_ready); else n_pass++;
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_chk++;
                if (qa.size() == 0) $display("FAIL spurious_output got=%h want=none", out_b);
                else begin
                    ea = qa.pop_front(); emd = qm.pop_front(); et = qt.pop_front();
                    eb = model_exp(ea, emd, tol);
                    if (!near(out_b, eb, tol) || out_tag !== et)
                        $display("FAIL stream[%0d] a=%h mode=%b got=%h/%h want=%h(+-%0d)/%h", recv, ea, emd, out_b, out_tag, eb, tol, et);
                    else n_pass++;
                end
                recv++;
            end
            acc = in_valid && in_ready === 1'b1;
            if (acc) begin
                qa.push_back(in_a); qm.push_back(in_mode); qt.push_back(in_tag);
            end
            stalled = out_valid === 1'b1 && !out_ready;
            hb = out_b;
            ht = out_tag;
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_chk++; if (recv !== n) $display("FAIL stream_count got=%0d want=%0d", recv, n); else n_pass++;
        if (!bp) begin
            n_chk++; if (cyc !== n + 3) $display("FAIL throughput_cycles got=%0d want=%0d", cyc, n + 3); else n_pass++;
        end
    endtask

    task automatic test_random();
        stream(300, 1'b0);
    endtask

    task automatic test_back_to_back();
        stream(8, 1'b1);
        stream(40, 1'b1);
    endtask

    task automatic test_reset_flight();
        logic [31:0] b;
        logic [3:0]  bt;
        int          lat;
        bit          seen;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 32'h40800000 + 32'(i) * 32'h00100000; in_mode = 1'b0; in_tag = 4'(i);
            @(posedge clk); #1;
        end
        rst = 1'b1; in_valid = 1'b1; in_a = 32'h3F800000;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_chk++; if (seen) $display("FAIL flush_after_reset got=output want=none"); else n_pass++;
        xfer(32'h40000000, 1'b0, 4'hA, b, bt, lat);
        n_chk++; if (lat !== 3) $display("FAIL post_reset_latency got=%0d want=3", lat); else n_pass++;
        n_chk++; if (b !== 32'h3F000000) $display("FAIL post_reset_result got=%h want=3f000000", b); else n_pass++;
        n_chk++; if (bt !== 4'hA) $display("FAIL post_reset_tag got=%h want=a", bt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_flight();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
